// File: rtl/drive_cmd_pkg.sv
// Shared drive-command definitions: command enum, ASCII encoding table and decoder,
// plus the receive FSM state type exposed for debug.
package drive_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_STOP,
        CMD_FWD,
        CMD_BACK,
        CMD_LEFT,
        CMD_RIGHT,
        CMD_SPIN
    } drive_cmd_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    localparam logic [7:0] ASCII_STOP  = 8'h53;  // 'S'
    localparam logic [7:0] ASCII_FWD   = 8'h46;  // 'F'
    localparam logic [7:0] ASCII_BACK  = 8'h42;  // 'B'
    localparam logic [7:0] ASCII_LEFT  = 8'h4C;  // 'L'
    localparam logic [7:0] ASCII_RIGHT = 8'h52;  // 'R'
    localparam logic [7:0] ASCII_SPIN  = 8'h41;  // 'A'

    typedef struct packed {
        logic       hit;
        drive_cmd_t cmd;
    } cmd_decode_t;

    // Inverse of command_translator; only the uppercase letters are legal.
    function automatic cmd_decode_t ascii_to_cmd(input logic [7:0] ch);
        cmd_decode_t d;
        d.hit = 1'b1;
        d.cmd = CMD_STOP;
        case (ch)
            ASCII_STOP:  d.cmd = CMD_STOP;
            ASCII_FWD:   d.cmd = CMD_FWD;
            ASCII_BACK:  d.cmd = CMD_BACK;
            ASCII_LEFT:  d.cmd = CMD_LEFT;
            ASCII_RIGHT: d.cmd = CMD_RIGHT;
            ASCII_SPIN:  d.cmd = CMD_SPIN;
            default:     d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART deserialiser: input synchroniser, mid-bit sampling FSM and baud counter.
// data_valid / frame_err are single-cycle pulses with no back-pressure; the consumer must take them.
module uart_rx
    import drive_cmd_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_in,
    output logic [7:0] data_rx,
    output logic       data_valid,
    output logic       frame_err,
    output rx_state_t  state
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    rx_state_t              state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [2:0]             bit_idx, bit_n;
    logic [7:0]             shift, shift_n, data_n;
    logic                   valid_n, ferr_n;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data_rx    <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], uart_in};
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            shift      <= shift_n;
            data_rx    <= data_n;
            data_valid <= valid_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        data_n  = data_rx;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_s) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = RX_START;
                end
            end
            RX_START: begin
                // Re-check the line at mid start bit so short glitches are dropped.
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_s;
                    bit_n            = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                // Leaving at mid-stop lets a following start edge be caught with no idle gap.
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = RX_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = RX_BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx_s) state_n = RX_IDLE;
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Drive-command link receiver: uart_rx followed by one registered ASCII-to-command decode stage.
// cmd_valid / cmd_unknown pulse one cycle after data_valid and never together.
module uart_cmd_rx
    import drive_cmd_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_in,
    output logic [7:0] data_rx,
    output logic       data_valid,
    output logic       frame_err,
    output drive_cmd_t command,
    output logic       cmd_valid,
    output logic       cmd_unknown,
    output rx_state_t  rx_state
);

    cmd_decode_t dec;

    uart_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_uart_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .uart_in    (uart_in),
        .data_rx    (data_rx),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .state      (rx_state)
    );

    assign dec = ascii_to_cmd(data_rx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            command     <= CMD_STOP;
            cmd_valid   <= 1'b0;
            cmd_unknown <= 1'b0;
        end else begin
            cmd_valid   <= data_valid && dec.hit;
            cmd_unknown <= data_valid && !dec.hit;
            if (data_valid && dec.hit) command <= dec.cmd;
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 50 MHz / 115200 baud (434 clocks per bit).
module tb_uart_cmd_rx;
    import drive_cmd_pkg::*;

    localparam int CPB = 434;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_in = 1'b1;
    logic [7:0] data_rx;
    logic       data_valid;
    logic       frame_err;
    drive_cmd_t command;
    logic       cmd_valid;
    logic       cmd_unknown;
    rx_state_t  rx_state;

    uart_cmd_rx #(
        .CLK_FREQ    (50_000_000),
        .BAUD        (115_200),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .uart_in     (uart_in),
        .data_rx     (data_rx),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .command     (command),
        .cmd_valid   (cmd_valid),
        .cmd_unknown (cmd_unknown),
        .rx_state    (rx_state)
    );

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [2:0] exp_cmd_q[$];
    int dv_cnt = 0, fe_cnt = 0, cv_cnt = 0, cu_cnt = 0;
    int excl_cnt = 0, orphan_cnt = 0;
    logic prev_dv = 1'b0;
    int dv_b, fe_b, cv_b, cu_b;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt++;
            if (exp_q.size() == 0) check("dv_spurious", data_valid, 1'b0);
            else                   check("data_rx", data_rx, exp_q.pop_front());
        end
        if (cmd_valid) begin
            cv_cnt++;
            if (exp_cmd_q.size() == 0) check("cv_spurious", cmd_valid, 1'b0);
            else                       check("command_seq", command, exp_cmd_q.pop_front());
        end
        if (frame_err)   fe_cnt++;
        if (cmd_unknown) cu_cnt++;
        if (cmd_valid && cmd_unknown) excl_cnt++;
        if ((cmd_valid || cmd_unknown) && !prev_dv) orphan_cnt++;
        prev_dv = data_valid;
    end

    // ---------------- drivers ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int cpb);
        uart_in = b;
        wait_clks(cpb);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int cpb);
        send_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) send_bit(b[i], cpb);
        send_bit(stop, cpb);
    endtask

    task automatic mark();
        dv_b = dv_cnt; fe_b = fe_cnt; cv_b = cv_cnt; cu_b = cu_cnt;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b41;
        wait_clks(5);

        // reset state
        check("rst_data_rx", data_rx, 8'h00);
        check("rst_command", command, CMD_STOP);
        check("rst_pulses", {data_valid, frame_err, cmd_valid, cmd_unknown}, 4'b0000);
        check("rst_state", rx_state, RX_IDLE);
        reset_n = 1'b1;
        wait_clks(CPB);

        // 1: single 'F'
        mark();
        exp_q.push_back(8'h46); exp_cmd_q.push_back(CMD_FWD);
        send_byte(8'h46, 1'b1, CPB);
        wait_clks(CPB);
        check("t1_dv", dv_cnt - dv_b, 1);
        check("t1_cv", cv_cnt - cv_b, 1);
        check("t1_command", command, CMD_FWD);
        check("t1_fe_cu", (fe_cnt - fe_b) + (cu_cnt - cu_b), 0);

        // 2: 'L' then 'R' with no idle bit between frames
        mark();
        exp_q.push_back(8'h4C); exp_cmd_q.push_back(CMD_LEFT);
        exp_q.push_back(8'h52); exp_cmd_q.push_back(CMD_RIGHT);
        send_byte(8'h4C, 1'b1, CPB);
        send_byte(8'h52, 1'b1, CPB);
        wait_clks(CPB);
        check("t2_dv", dv_cnt - dv_b, 2);
        check("t2_cv", cv_cnt - cv_b, 2);
        check("t2_command", command, CMD_RIGHT);
        check("t2_data_rx", data_rx, 8'h52);

        // 3: 100-clock glitch
        mark();
        uart_in = 1'b0;
        wait_clks(100);
        uart_in = 1'b1;
        wait_clks(CPB);
        check("t3_pulses", (dv_cnt - dv_b) + (fe_cnt - fe_b) + (cv_cnt - cv_b) + (cu_cnt - cu_b), 0);
        check("t3_state", rx_state, RX_IDLE);

        // 4: framing error, long break, then a good 'B'
        mark();
        send_byte(8'h53, 1'b0, CPB);
        wait_clks(2000);
        check("t4_state_break", rx_state, RX_BREAK);
        uart_in = 1'b1;
        wait_clks(CPB);
        check("t4_fe", fe_cnt - fe_b, 1);
        check("t4_dv_bad", dv_cnt - dv_b, 0);
        check("t4_state", rx_state, RX_IDLE);
        check("t4_data_held", data_rx, 8'h52);
        exp_q.push_back(8'h42); exp_cmd_q.push_back(CMD_BACK);
        send_byte(8'h42, 1'b1, CPB);
        wait_clks(CPB);
        check("t4_dv", dv_cnt - dv_b, 1);
        check("t4_command", command, CMD_BACK);
        check("t4_fe_total", fe_cnt - fe_b, 1);

        // 5: 'F' then unknown 'Z'
        mark();
        exp_q.push_back(8'h46); exp_cmd_q.push_back(CMD_FWD);
        exp_q.push_back(8'h5A);
        send_byte(8'h46, 1'b1, CPB);
        send_byte(8'h5A, 1'b1, CPB);
        wait_clks(CPB);
        check("t5_cu", cu_cnt - cu_b, 1);
        check("t5_cv", cv_cnt - cv_b, 1);
        check("t5_command", command, CMD_FWD);
        check("t5_data_rx", data_rx, 8'h5A);

        // 6: reset during bit 4, then 'A' at nominal and +/-2% baud
        mark();
        b41 = 8'h41;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bit(b41[i], CPB);
        uart_in = b41[4];
        wait_clks(CPB / 2);
        reset_n = 1'b0;
        wait_clks(3);
        check("t6_rst_data_rx", data_rx, 8'h00);
        check("t6_rst_command", command, CMD_STOP);
        check("t6_rst_pulses", {data_valid, frame_err, cmd_valid, cmd_unknown}, 4'b0000);
        check("t6_rst_state", rx_state, RX_IDLE);
        uart_in = 1'b1;
        wait_clks(50);
        reset_n = 1'b1;
        wait_clks(2 * CPB);
        check("t6_no_stale", (dv_cnt - dv_b) + (fe_cnt - fe_b), 0);
        check("t6_data_rx_idle", data_rx, 8'h00);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(8'h41); exp_cmd_q.push_back(CMD_SPIN);
        end
        send_byte(8'h41, 1'b1, CPB);
        wait_clks(CPB);
        check("t6_command", command, CMD_SPIN);
        send_byte(8'h41, 1'b1, 425);
        wait_clks(CPB);
        send_byte(8'h41, 1'b1, 443);
        wait_clks(CPB);
        check("t6_dv", dv_cnt - dv_b, 3);
        check("t6_cv", cv_cnt - cv_b, 3);
        check("t6_fe", fe_cnt - fe_b, 0);

        // global properties
        check("excl_violations", excl_cnt, 0);
        check("orphan_decodes", orphan_cnt, 0);
        check("exp_q_left", exp_q.size(), 0);
        check("exp_cmd_q_left", exp_cmd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
